// File: rtl/slurm32_cpu_register_file_if.sv
// rtl/slurm32_cpu_register_file_if.sv - writeback/read-port bundle between the pipeline and the register file
// Pipeline side is master; the register file is slave.
interface slurm32_cpu_register_file_if #(
  parameter int REGISTER_BITS = 8,
  parameter int BITS          = 32
);
  logic [REGISTER_BITS-1:0] reg_wr_sel;
  logic [BITS-1:0]          reg_in;
  logic [REGISTER_BITS-1:0] regA_sel;
  logic [REGISTER_BITS-1:0] regB_sel;
  logic                     stall;
  logic [BITS-1:0]          regA_out;
  logic [BITS-1:0]          regB_out;
  logic                     ready;

  modport master (
    output reg_wr_sel, reg_in, regA_sel, regB_sel, stall,
    input  regA_out, regB_out, ready
  );

  modport slave (
    input  reg_wr_sel, reg_in, regA_sel, regB_sel, stall,
    output regA_out, regB_out, ready
  );
endinterface

// File: rtl/slurm32_cpu_register_file.sv
// rtl/slurm32_cpu_register_file.sv - SLURM32 2-read/1-write register file with bypass and stall hold
// Optional post-reset clearing sequencer enabled by defining SLURM32_REGFILE_CLEAR_EN.
module slurm32_cpu_register_file #(
  parameter int REGISTER_BITS = 8,
  parameter int BITS          = 32
) (
  input logic                     CLK,
  input logic                     RST,
  slurm32_cpu_register_file_if.slave bus
);
  localparam int DEPTH = 1 << REGISTER_BITS;

  logic [BITS-1:0]          mem [DEPTH];
  logic [REGISTER_BITS-1:0] addr_a_q, addr_b_q;
  logic [REGISTER_BITS-1:0] eff_a, eff_b;
  logic [BITS-1:0]          rd_a, rd_b;
  logic [BITS-1:0]          out_a_q, out_b_q;
  logic                     run;
  logic                     mem_we;
  logic [REGISTER_BITS-1:0] mem_waddr;
  logic [BITS-1:0]          mem_wdata;

`ifdef SLURM32_REGFILE_CLEAR_EN
  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t                   state_q, state_d;
  logic [REGISTER_BITS-1:0] clr_cnt_q, clr_cnt_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // The counter wraps to 0 on the last clear write, leaving it parked for the next reset.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + {{(REGISTER_BITS-1){1'b0}}, 1'b1};
      if (clr_cnt_q == {REGISTER_BITS{1'b1}}) begin
        state_d = ST_RUN;
      end
    end
  end

  assign run = (state_q == ST_RUN);

  always_comb begin
    if (run) begin
      mem_we    = (bus.reg_wr_sel != '0);
      mem_waddr = bus.reg_wr_sel;
      mem_wdata = bus.reg_in;
    end else begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q;
      mem_wdata = '0;
    end
  end
`else
  logic run_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  assign run       = run_q;
  assign mem_we    = run_q && (bus.reg_wr_sel != '0);
  assign mem_waddr = bus.reg_wr_sel;
  assign mem_wdata = bus.reg_in;
`endif

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // While stalled the ports re-read the held address every cycle, so a write landing on it is picked up.
  assign eff_a = bus.stall ? addr_a_q : bus.regA_sel;
  assign eff_b = bus.stall ? addr_b_q : bus.regB_sel;

  always_comb begin
    if (eff_a == '0) begin
      rd_a = '0;
    end else if (eff_a == bus.reg_wr_sel) begin
      rd_a = bus.reg_in;
    end else begin
      rd_a = mem[eff_a];
    end
  end

  always_comb begin
    if (eff_b == '0) begin
      rd_b = '0;
    end else if (eff_b == bus.reg_wr_sel) begin
      rd_b = bus.reg_in;
    end else begin
      rd_b = mem[eff_b];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_a_q <= '0;
      addr_b_q <= '0;
      out_a_q  <= '0;
      out_b_q  <= '0;
    end else begin
      if (!bus.stall) begin
        addr_a_q <= bus.regA_sel;
        addr_b_q <= bus.regB_sel;
      end
      out_a_q <= run ? rd_a : '0;
      out_b_q <= run ? rd_b : '0;
    end
  end

  assign bus.regA_out = out_a_q;
  assign bus.regB_out = out_b_q;
  assign bus.ready    = run;
endmodule

// File: tb/tb_slurm32_cpu_register_file.sv
// tb/tb_slurm32_cpu_register_file.sv - directed self-checking bench for slurm32_cpu_register_file
// Clear-sequencer checks compile in when SLURM32_REGFILE_CLEAR_EN is defined.
module tb_slurm32_cpu_register_file;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   errors = 0;

  slurm32_cpu_register_file_if #(.REGISTER_BITS(8), .BITS(32)) rf_if ();

  slurm32_cpu_register_file #(.REGISTER_BITS(8), .BITS(32)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (rf_if)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    rf_if.reg_wr_sel = 8'd0;
    rf_if.reg_in     = 32'd0;
    rf_if.regA_sel   = 8'd0;
    rf_if.regB_sel   = 8'd0;
    rf_if.stall      = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    RST = 1'b1;
    repeat (3) tick();
    checks++;
    if (rf_if.ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready got=%0b exp=0", rf_if.ready);
    end
    checks++;
    if (rf_if.regA_out !== 32'd0) begin
      errors++; $display("FAIL reset_regA got=%h exp=00000000", rf_if.regA_out);
    end
    checks++;
    if (rf_if.regB_out !== 32'd0) begin
      errors++; $display("FAIL reset_regB got=%h exp=00000000", rf_if.regB_out);
    end
    RST = 1'b0;
`ifdef SLURM32_REGFILE_CLEAR_EN
    for (int i = 0; i < 256; i++) begin
      tick();
      checks++;
      if (rf_if.ready !== (i == 255)) begin
        errors++; $display("FAIL clear_ready edge=%0d got=%0b exp=%0b", i, rf_if.ready, (i == 255));
      end
    end
    for (int r = 1; r < 256; r++) begin
      rf_if.regA_sel = r[7:0];
      rf_if.regB_sel = r[7:0];
      tick();
      checks++;
      if (rf_if.regA_out !== 32'd0 || rf_if.regB_out !== 32'd0) begin
        errors++; $display("FAIL clear_contents r=%0d gotA=%h gotB=%h exp=00000000", r, rf_if.regA_out, rf_if.regB_out);
      end
    end
    idle_inputs();
`else
    tick();
    checks++;
    if (rf_if.ready !== 1'b1) begin
      errors++; $display("FAIL release_ready got=%0b exp=1", rf_if.ready);
    end
`endif
  endtask

  task automatic test_write_read();
    rf_if.reg_wr_sel = 8'd5;
    rf_if.reg_in     = 32'hDEADBEEF;
    tick();
    rf_if.reg_wr_sel = 8'd0;
    rf_if.reg_in     = 32'h0;
    rf_if.regA_sel   = 8'd5;
    rf_if.regB_sel   = 8'd5;
    tick();
    checks++;
    if (rf_if.regA_out !== 32'hDEADBEEF) begin
      errors++; $display("FAIL write_read_A got=%h exp=deadbeef", rf_if.regA_out);
    end
    checks++;
    if (rf_if.regB_out !== 32'hDEADBEEF) begin
      errors++; $display("FAIL write_read_B got=%h exp=deadbeef", rf_if.regB_out);
    end
    idle_inputs();
  endtask

  task automatic test_bypass();
    rf_if.reg_wr_sel = 8'd7;
    rf_if.reg_in     = 32'h0;
    tick();
    rf_if.reg_in   = 32'h12345678;
    rf_if.regA_sel = 8'd7;
    rf_if.regB_sel = 8'd7;
    tick();
    checks++;
    if (rf_if.regA_out !== 32'h12345678) begin
      errors++; $display("FAIL bypass_A got=%h exp=12345678", rf_if.regA_out);
    end
    checks++;
    if (rf_if.regB_out !== 32'h12345678) begin
      errors++; $display("FAIL bypass_B got=%h exp=12345678", rf_if.regB_out);
    end
    rf_if.reg_wr_sel = 8'd0;
    rf_if.reg_in     = 32'h0;
    tick();
    checks++;
    if (rf_if.regA_out !== 32'h12345678) begin
      errors++; $display("FAIL bypass_array_A got=%h exp=12345678", rf_if.regA_out);
    end
    idle_inputs();
  endtask

  task automatic test_r0();
    rf_if.reg_wr_sel = 8'd0;
    rf_if.reg_in     = 32'hFFFFFFFF;
    rf_if.regA_sel   = 8'd0;
    rf_if.regB_sel   = 8'd0;
    tick();
    checks++;
    if (rf_if.regA_out !== 32'd0 || rf_if.regB_out !== 32'd0) begin
      errors++; $display("FAIL r0_bypass gotA=%h gotB=%h exp=00000000", rf_if.regA_out, rf_if.regB_out);
    end
    rf_if.reg_in = 32'h0;
    tick();
    checks++;
    if (rf_if.regA_out !== 32'd0 || rf_if.regB_out !== 32'd0) begin
      errors++; $display("FAIL r0_read gotA=%h gotB=%h exp=00000000", rf_if.regA_out, rf_if.regB_out);
    end
    idle_inputs();
  endtask

  task automatic test_stall();
    rf_if.reg_wr_sel = 8'd9;
    rf_if.reg_in     = 32'h1;
    tick();
    rf_if.reg_wr_sel = 8'd3;
    rf_if.reg_in     = 32'h33;
    tick();
    rf_if.reg_wr_sel = 8'd0;
    rf_if.reg_in     = 32'h0;
    rf_if.regA_sel   = 8'd9;
    rf_if.regB_sel   = 8'd3;
    tick();
    checks++;
    if (rf_if.regA_out !== 32'h1) begin
      errors++; $display("FAIL stall_pre got=%h exp=00000001", rf_if.regA_out);
    end
    rf_if.stall      = 1'b1;
    rf_if.reg_wr_sel = 8'd9;
    rf_if.reg_in     = 32'h2;
    rf_if.regA_sel   = 8'd3;
    rf_if.regB_sel   = 8'd9;
    tick();
    checks++;
    if (rf_if.regA_out !== 32'h2) begin
      errors++; $display("FAIL stall_write_A got=%h exp=00000002", rf_if.regA_out);
    end
    checks++;
    if (rf_if.regB_out !== 32'h33) begin
      errors++; $display("FAIL stall_hold_B got=%h exp=00000033", rf_if.regB_out);
    end
    rf_if.reg_wr_sel = 8'd0;
    rf_if.reg_in     = 32'h0;
    tick();
    checks++;
    if (rf_if.regA_out !== 32'h2) begin
      errors++; $display("FAIL stall_array_A got=%h exp=00000002", rf_if.regA_out);
    end
    rf_if.stall = 1'b0;
    tick();
    checks++;
    if (rf_if.regA_out !== 32'h33) begin
      errors++; $display("FAIL unstall_A got=%h exp=00000033", rf_if.regA_out);
    end
    checks++;
    if (rf_if.regB_out !== 32'h2) begin
      errors++; $display("FAIL unstall_B got=%h exp=00000002", rf_if.regB_out);
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    for (int i = 10; i < 14; i++) begin
      rf_if.reg_wr_sel = i[7:0];
      rf_if.reg_in     = 32'hA000_0000 + i;
      tick();
    end
    rf_if.reg_wr_sel = 8'd0;
    rf_if.reg_in     = 32'h0;
    for (int i = 10; i < 13; i++) begin
      rf_if.regA_sel = i[7:0];
      rf_if.regB_sel = i[7:0] + 8'd1;
      tick();
      checks++;
      if (rf_if.regA_out !== 32'hA000_0000 + i || rf_if.regB_out !== 32'hA000_0001 + i) begin
        errors++; $display("FAIL back_to_back i=%0d gotA=%h gotB=%h expA=%h expB=%h",
                           i, rf_if.regA_out, rf_if.regB_out, 32'hA000_0000 + i, 32'hA000_0001 + i);
      end
    end
    idle_inputs();
  endtask

  task automatic test_mid_reset();
    rf_if.regA_sel = 8'd5;
    RST = 1'b1;
    tick();
    checks++;
    if (rf_if.ready !== 1'b0 || rf_if.regA_out !== 32'd0) begin
      errors++; $display("FAIL mid_reset_hold ready=%0b A=%h exp ready=0 A=00000000", rf_if.ready, rf_if.regA_out);
    end
    RST = 1'b0;
`ifdef SLURM32_REGFILE_CLEAR_EN
    repeat (100) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    for (int i = 0; i < 256; i++) begin
      tick();
      checks++;
      if (rf_if.ready !== (i == 255)) begin
        errors++; $display("FAIL mid_clear_ready edge=%0d got=%0b exp=%0b", i, rf_if.ready, (i == 255));
      end
    end
    tick();
    checks++;
    if (rf_if.regA_out !== 32'd0) begin
      errors++; $display("FAIL mid_clear_r5 got=%h exp=00000000", rf_if.regA_out);
    end
`else
    tick();
    checks++;
    if (rf_if.ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset_ready got=%0b exp=1", rf_if.ready);
    end
    tick();
    checks++;
    if (rf_if.regA_out !== 32'hDEADBEEF) begin
      errors++; $display("FAIL mid_reset_r5 got=%h exp=deadbeef", rf_if.regA_out);
    end
`endif
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_write_read();
    test_bypass();
    test_r0();
    test_stall();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
